// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared state encoding and constants for the SCCB config master
package sccb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_BITS,
        S_STOP,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam int          SCCB_BITS  = 27;
    localparam logic [15:0] END_MARKER = 16'hFFFF;

    localparam int DEF_T_LOW      = 165;
    localparam int DEF_T_HIGH     = 165;
    localparam int DEF_T_DAT      = 75;
    localparam int DEF_T_SU_STA   = 80;
    localparam int DEF_T_HD_STA   = 80;
    localparam int DEF_T_SU_STO   = 80;
    localparam int DEF_T_BUF      = 150;
    localparam int DEF_DELAY_UNIT = 100000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// rtl/sccb_cfg_rom.sv - synchronous 1-cycle OV7670 init table feeding sccb_cfg_master
module sccb_cfg_rom
    import sccb_pkg::*;
#(
    parameter int NUM_REGS = 64,
    parameter int IDX_W    = 6
) (
    input  logic             i_clock,
    input  logic [IDX_W-1:0] i_idx,
    output logic [15:0]      o_entry
);

    // Soft reset first, then 1 ms settle before the remaining registers.
    function automatic logic [15:0] rom_word(input logic [IDX_W-1:0] a);
        if (int'(a) >= NUM_REGS) return END_MARKER;
        case (int'(a))
            0:       return 16'h1280;
            1:       return 16'hF001;
            2:       return 16'h1100;
            3:       return 16'h1204;
            4:       return 16'h0C00;
            5:       return 16'h3E00;
            6:       return 16'h8C00;
            7:       return 16'h40D0;
            8:       return 16'h3A04;
            9:       return 16'h1438;
            10:      return 16'h4FB3;
            11:      return 16'h50B3;
            12:      return 16'h5100;
            13:      return 16'h523D;
            14:      return 16'h53A7;
            15:      return 16'h54E4;
            16:      return 16'h589E;
            default: return END_MARKER;
        endcase
    endfunction

    always_ff @(posedge i_clock) begin
        o_entry <= rom_word(i_idx);
    end

endmodule

// File: rtl/sccb_cfg_master.sv
// rtl/sccb_cfg_master.sv - table-driven SCCB 3-phase write master
module sccb_cfg_master
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID     = 8'h42,
    parameter int         NUM_REGS   = 64,
    parameter int         IDX_W      = 6,
    parameter int         T_LOW      = DEF_T_LOW,
    parameter int         T_HIGH     = DEF_T_HIGH,
    parameter int         T_DAT      = DEF_T_DAT,
    parameter int         T_SU_STA   = DEF_T_SU_STA,
    parameter int         T_HD_STA   = DEF_T_HD_STA,
    parameter int         T_SU_STO   = DEF_T_SU_STO,
    parameter int         T_BUF      = DEF_T_BUF,
    parameter logic [7:0] DELAY_ADDR = 8'hF0,
    parameter int         DELAY_UNIT = DEF_DELAY_UNIT
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    output logic [IDX_W-1:0] o_tbl_idx,
    input  logic [15:0]      i_tbl_entry,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sccb_clk,
    output logic             o_sccb_dat
);

    localparam int CNT_W = $clog2(max3(T_LOW + T_HIGH, T_SU_STA + T_HD_STA,
                                       T_LOW + T_SU_STO + T_BUF));
    localparam int DLY_W = 8 + $clog2(DELAY_UNIT);

    localparam logic [CNT_W-1:0] C_LOW      = CNT_W'(T_LOW);
    localparam logic [CNT_W-1:0] C_DAT      = CNT_W'(T_DAT);
    localparam logic [CNT_W-1:0] C_BIT_END  = CNT_W'(T_LOW + T_HIGH - 1);
    localparam logic [CNT_W-1:0] C_STA_FALL = CNT_W'(T_SU_STA);
    localparam logic [CNT_W-1:0] C_STA_END  = CNT_W'(T_SU_STA + T_HD_STA - 1);
    localparam logic [CNT_W-1:0] C_STO_RISE = CNT_W'(T_LOW + T_SU_STO);
    localparam logic [CNT_W-1:0] C_STO_END  = CNT_W'(T_LOW + T_SU_STO + T_BUF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REGS - 1);
    localparam logic [4:0]       LAST_BIT   = 5'(SCCB_BITS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [4:0]           r_bit_cnt;
    logic [DLY_W-1:0]     r_dly;
    logic [15:0]          r_entry;
    logic                 r_start_q;
    logic                 r_scl;
    logic                 r_sda;
    logic [IDX_W-1:0]     r_idx;
    logic                 w_edge;
    logic                 w_decode;
    logic                 w_slot_end;
    logic                 w_scl;
    logic                 w_sda;
    logic [SCCB_BITS-1:0] w_frame;

    assign w_edge     = i_start & ~r_start_q;
    assign w_decode   = (r_state == S_FETCH) && (r_cnt != '0);
    assign w_slot_end = (r_state == S_BITS) && (r_cnt == C_BIT_END);
    // ACK slots are released high; the slave's answer is never sampled.
    assign w_frame    = {DEV_ID, 1'b1, r_entry[15:8], 1'b1, r_entry[7:0], 1'b1};

    assign o_tbl_idx  = r_idx;
    assign o_sccb_clk = r_scl;
    assign o_sccb_dat = r_sda;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_edge) w_next = S_FETCH;
            S_FETCH: begin
                if (w_decode) begin
                    if (i_tbl_entry == END_MARKER)
                        w_next = S_FINISH;
                    else if (i_tbl_entry[15:8] == DELAY_ADDR)
                        w_next = (i_tbl_entry[7:0] == 8'd0) ? S_NEXT : S_WAIT;
                    else
                        w_next = S_START;
                end
            end
            S_START:  if (r_cnt == C_STA_END) w_next = S_BITS;
            S_BITS:   if (w_slot_end && r_bit_cnt == LAST_BIT) w_next = S_STOP;
            S_STOP:   if (r_cnt == C_STO_END) w_next = S_NEXT;
            S_WAIT:   if (r_dly == DLY_W'(1)) w_next = S_NEXT;
            S_NEXT:   w_next = (r_idx == IDX_LAST) ? S_FINISH : S_FETCH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_scl  = 1'b1;
        w_sda  = 1'b1;
        o_done = (r_state == S_FINISH);
        o_busy = (r_state != S_IDLE) && (r_state != S_FINISH);
        case (r_state)
            S_START: w_sda = (r_cnt < C_STA_FALL);
            S_BITS: begin
                w_scl = (r_cnt >= C_LOW);
                w_sda = (r_cnt == C_DAT) ? w_frame[LAST_BIT - r_bit_cnt] : r_sda;
            end
            S_STOP: begin
                w_scl = (r_cnt >= C_LOW);
                if (r_cnt == C_DAT)          w_sda = 1'b0;
                else if (r_cnt >= C_STO_RISE) w_sda = 1'b1;
                else                          w_sda = r_sda;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_dly     <= '0;
            r_entry   <= '0;
            r_start_q <= 1'b0;
            r_scl     <= 1'b1;
            r_sda     <= 1'b1;
            r_idx     <= '0;
        end else begin
            r_start_q <= i_start;
            r_scl     <= w_scl;
            r_sda     <= w_sda;

            if (w_next != r_state || w_slot_end)
                r_cnt <= '0;
            else if (r_state inside {S_FETCH, S_START, S_BITS, S_STOP})
                r_cnt <= r_cnt + 1'b1;

            if (r_state == S_START)
                r_bit_cnt <= '0;
            else if (w_slot_end)
                r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_decode) begin
                r_entry <= i_tbl_entry;
                r_dly   <= DLY_W'(i_tbl_entry[7:0]) * DLY_W'(DELAY_UNIT);
            end else if (r_state == S_WAIT) begin
                r_dly <= r_dly - 1'b1;
            end

            if (r_state == S_IDLE && w_edge)
                r_idx <= '0;
            else if (r_state == S_NEXT && r_idx != IDX_LAST)
                r_idx <= r_idx + 1'b1;
            else if (r_state == S_FINISH)
                r_idx <= '0;
        end
    end

endmodule

// File: tb/tb_sccb_cfg_master.sv
// tb/tb_sccb_cfg_master.sv - self-checking bench for sccb_cfg_master
module tb_sccb_cfg_master;

    localparam int         NREG = 4;
    localparam int         IW   = 3;
    localparam int         TB   = 4;
    localparam int         DU   = 10;
    localparam logic [7:0] DEV  = 8'h42;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] idx;
    logic [15:0]   entry;
    logic          busy, done, scl, sda;
    logic [15:0]   tbl [NREG];

    sccb_cfg_master #(
        .DEV_ID(DEV), .NUM_REGS(NREG), .IDX_W(IW),
        .T_LOW(8), .T_HIGH(8), .T_DAT(3),
        .T_SU_STA(4), .T_HD_STA(4), .T_SU_STO(4), .T_BUF(TB),
        .DELAY_ADDR(8'hF0), .DELAY_UNIT(DU)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start),
        .o_tbl_idx(idx), .i_tbl_entry(entry),
        .o_busy(busy), .o_done(done),
        .o_sccb_clk(scl), .o_sccb_dat(sda)
    );

    always #5 clk = ~clk;

    always @(posedge clk) entry <= (int'(idx) < NREG) ? tbl[idx[1:0]] : 16'hFFFF;

    // Bus decoder: rebuilds each START..STOP frame from SCL rising-edge samples.
    logic          clr_req = 1'b0;
    logic          p_scl = 1'b1, p_sda = 1'b1, in_frame = 1'b0, after_stop = 1'b0;
    logic [IW-1:0] p_idx = '0, max_idx = '0;
    logic [31:0]   sh = '0;
    int            nb = 0, gap = 0, done_cnt = 0, busy_err = 0;
    logic [31:0]   frames[$];
    int            nbits[$];
    int            gaps[$];
    int            idx_log[$];

    always @(negedge clk) begin
        if (clr_req) begin
            frames.delete(); nbits.delete(); gaps.delete(); idx_log.delete();
            after_stop = 1'b0; done_cnt = 0; busy_err = 0; max_idx = '0;
        end else if (!rst) begin
            if (scl && p_scl && p_sda && !sda) begin
                if (after_stop) gaps.push_back(gap);
                in_frame = 1'b1; after_stop = 1'b0; nb = 0; sh = '0;
            end else if (scl && p_scl && !p_sda && sda && in_frame) begin
                frames.push_back(sh); nbits.push_back(nb);
                in_frame = 1'b0; after_stop = 1'b1; gap = 0;
            end
            if (scl && !p_scl && in_frame) begin
                sh = {sh[30:0], sda}; nb++;
            end
            if (after_stop && scl && sda) gap++;
            if (idx !== p_idx) idx_log.push_back(int'(idx));
            if (idx > max_idx) max_idx = idx;
            if (done) begin
                done_cnt++;
                if (busy) busy_err++;
            end
        end
        p_scl = scl; p_sda = sda; p_idx = idx;
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_frames[$];
    int          exp_idx[$];
    int          exp_last;
    int          g_norm;
    bit          ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk); #1 clr_req = 1'b1;
        @(posedge clk); #1 clr_req = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Reference: walk the table until the end marker or the last index, one frame per write.
    task automatic build_model();
        logic [15:0] e;
        exp_frames.delete(); exp_idx.delete();
        exp_last = NREG - 1;
        for (int i = 0; i < NREG; i++) begin
            e = tbl[i];
            if (e == 16'hFFFF) begin
                exp_last = i;
                break;
            end
            if (e[15:8] != 8'hF0)
                exp_frames.push_back({4'h0, DEV, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1, 1'b0});
        end
        for (int j = 1; j <= exp_last; j++) exp_idx.push_back(j);
        if (exp_last > 0) exp_idx.push_back(0);
    endtask

    function automatic logic [15:0] rand_write();
        logic [7:0] sub;
        logic [7:0] dat;
        sub = 8'($urandom_range(0, 8'hEF));
        dat = 8'($urandom_range(0, 255));
        return {sub, dat};
    endfunction

    task automatic check_walk(input string tag, input int n_done);
        check($sformatf("%s_nframes", tag), 32'(frames.size()), 32'(exp_frames.size()));
        for (int i = 0; i < exp_frames.size() && i < frames.size(); i++) begin
            check($sformatf("%s_frame%0d", tag, i), frames[i], exp_frames[i]);
            check($sformatf("%s_sclrise%0d", tag, i), 32'(nbits[i]), 32'd28);
        end
        check($sformatf("%s_done_cnt", tag), 32'(done_cnt), 32'(n_done));
        check($sformatf("%s_busy_at_done", tag), 32'(busy_err), 32'd0);
        check($sformatf("%s_idx_steps", tag), 32'(idx_log.size()), 32'(exp_idx.size()));
        for (int i = 0; i < exp_idx.size() && i < idx_log.size(); i++)
            check($sformatf("%s_idx%0d", tag, i), 32'(idx_log[i]), 32'(exp_idx[i]));
        check($sformatf("%s_max_idx", tag), 32'(max_idx), 32'(exp_last));
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) tbl[i] = 16'hFFFF;
        #22 rst = 1'b0;
        #1;
        check("rst_scl",  32'(scl),  32'd1);
        check("rst_sda",  32'(sda),  32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx",  32'(idx),  32'd0);

        // Single write
        tbl[0] = 16'h1280; tbl[1] = 16'hFFFF;
        build_model(); clear_mon();
        pulse_start();
        check("t1_busy_high", 32'(busy), 32'd1);
        wait_done(3000, ok);
        check("t1_done_seen", 32'(ok), 32'd1);
        check("t1_busy_fall", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        check_walk("t1", 1);

        // Three writes, with a start edge mid-walk that must be ignored
        tbl[0] = 16'h3A04; tbl[1] = 16'h1204; tbl[2] = 16'h8C00; tbl[3] = 16'hFFFF;
        build_model(); clear_mon();
        pulse_start();
        repeat (200) @(posedge clk);
        pulse_start();
        wait_done(5000, ok);
        check("t2_done_seen", 32'(ok), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check_walk("t2", 1);
        check("t2_ngaps", 32'(gaps.size()), 32'd2);
        for (int i = 0; i < gaps.size(); i++)
            check($sformatf("t2_gap%0d_ge_tbuf", i), 32'(gaps[i] >= TB), 32'd1);
        g_norm = (gaps.size() > 0) ? gaps[0] : 0;
        check("t2_idle_after", 32'(busy), 32'd0);
        clear_mon();
        pulse_start();
        wait_done(5000, ok);
        check("t2b_done_seen", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        check_walk("t2b", 1);

        // Delay entry of 2 units between two random writes
        tbl[0] = rand_write(); tbl[1] = 16'hF002; tbl[2] = rand_write(); tbl[3] = 16'hFFFF;
        build_model(); clear_mon();
        pulse_start();
        wait_done(5000, ok);
        check("t3_done_seen", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        check_walk("t3", 1);
        check("t3_ngaps", 32'(gaps.size()), 32'd1);
        if (gaps.size() > 0)
            check("t3_delay_window",
                  32'((gaps[0] - g_norm >= 2 * DU - 2) && (gaps[0] - g_norm <= 2 * DU + 5)), 32'd1);

        // Random tables, including full tables with no end marker
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NREG; i++) begin
                int r;
                r = (it == 0) ? 0 : int'($urandom_range(0, 9));
                if (r < 6 || r == 9) tbl[i] = rand_write();
                else if (r < 8)      tbl[i] = {8'hF0, 8'($urandom_range(0, 3))};
                else                 tbl[i] = 16'hFFFF;
            end
            build_model(); clear_mon();
            pulse_start();
            wait_done(8000, ok);
            check($sformatf("rnd%0d_done_seen", it), 32'(ok), 32'd1);
            repeat (3) @(posedge clk);
            check_walk($sformatf("rnd%0d", it), 1);
        end

        // Reset in slot 10, then a clean walk
        tbl[0] = rand_write(); tbl[1] = 16'hFFFF;
        build_model(); clear_mon();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (in_frame && nb == 10 && !scl) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_reach_slot10", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_scl",  32'(scl),  32'd1);
        check("t5_async_sda",  32'(sda),  32'd1);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_idx",  32'(idx),  32'd0);
        @(posedge clk); #2 rst = 1'b0;
        clear_mon();
        pulse_start();
        wait_done(3000, ok);
        check("t5_done_seen", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        check_walk("t5", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
